flood_game_ctrl: RTL and testbench

Game-side responder to the menu's BEGIN_GAME/ACK_BEGIN_GAME handshake. It latches the chosen board size and colour count, looks up the try budget, and fills the board RAM with pseudo-random colours. During play it turns colour picks into flood requests for the flood engine, counts tries, and declares WIN or LOSE.

---
 rtl/flood_pkg.sv | 52 +++++
 rtl/flood_game_lfsr16.sv | 24 ++
 rtl/flood_game_ctrl.sv | 135 +++++++++++++
 tb/tb_flood_game_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flood_pkg.sv
// Shared types, widths and configuration helpers for the flood game controller.
// Holds the state encoding plus the try-budget lookup used at game start.
package flood_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_FILL  = 3'd2,
    S_PLAY  = 3'd3,
    S_FLOOD = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam int CELL_AW = 10;
  localparam int COLOR_W = 3;

  localparam logic [4:0] MAX_SIZE       = 5'd26;
  localparam logic [4:0] DEFAULT_SIZE   = 5'd14;
  localparam logic [3:0] DEFAULT_COLORS = 4'd6;

  // Legal sides are 2,6,..,26: all congruent to 2 mod 4.
  function automatic logic legal_cfg(
    input logic [4:0] size,
    input logic [3:0] colors
  );
    return (size[1:0] == 2'b10) && (size <= MAX_SIZE) &&
           (colors >= 4'd3) && (colors <= 4'd8);
  endfunction

  function automatic logic [7:0] budget(
    input logic [4:0] size,
    input logic [3:0] colors
  );
    logic [47:0] row;
    int          i;
    case (size)
      5'd2:  row = {8'd4,  8'd4,  8'd3,  8'd2,  8'd2,  8'd1};
      5'd6:  row = {8'd14, 8'd12, 8'd10, 8'd8,  8'd7,  8'd5};
      5'd10: row = {8'd23, 8'd20, 8'd17, 8'd14, 8'd11, 8'd8};
      5'd14: row = {8'd33, 8'd29, 8'd25, 8'd20, 8'd16, 8'd12};
      5'd18: row = {8'd42, 8'd37, 8'd32, 8'd26, 8'd21, 8'd16};
      5'd22: row = {8'd52, 8'd45, 8'd39, 8'd32, 8'd26, 8'd19};
      5'd26: row = {8'd61, 8'd54, 8'd46, 8'd38, 8'd30, 8'd23};
      default: row = '0;
    endcase
    i = (int'(colors) - 3) * 8;
    if (i < 0 || i > 40) return 8'd0;
    return row[i +: 8];
  endfunction

endpackage

// File: rtl/flood_game_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
// Exposes the low colour bits of the value it will hold after the next edge.
module flood_lfsr16
  import flood_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COLOR_W-1:0] rnd
);

  logic [15:0] q;
  logic [15:0] d;

  assign d   = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  assign rnd = d[COLOR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= d;
  end

endmodule

// File: rtl/flood_game_ctrl.sv
// Game-side controller: start handshake, random board fill, pick-to-flood
// sequencing, try counting and win/lose decision.
module flood_game_ctrl
  import flood_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic               MASTER_CLOCK,
  input  logic               RESET_N,
  input  logic               BEGIN_GAME,
  output logic               ACK_BEGIN_GAME,
  input  logic [4:0]         SIZE,
  input  logic [3:0]         COLOR_NUM,
  input  logic               ABORT,
  input  logic               PICK_VALID,
  input  logic [COLOR_W-1:0] PICK_COLOR,
  output logic               FLOOD_START,
  output logic [COLOR_W-1:0] FLOOD_COLOR,
  input  logic               FLOOD_DONE,
  input  logic               FLOOD_WON,
  output logic               WR_EN,
  output logic [CELL_AW-1:0] WR_ADDR,
  output logic [COLOR_W-1:0] WR_DATA,
  output logic [4:0]         GAME_SIZE,
  output logic [3:0]         GAME_COLORS,
  output logic [COLOR_W-1:0] CORNER_COLOR,
  output logic [7:0]         TRIES,
  output logic [7:0]         TOTAL_TRIES,
  output logic [2:0]         STATE
);

  state_t             state;
  logic [CELL_AW-1:0] cnt;
  logic [CELL_AW-1:0] cells;
  logic [COLOR_W-1:0] rnd;
  logic               cfg_ok;
  logic               fill_hit;
  logic               pick_ok;
  logic [7:0]         tries_inc;

  flood_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (MASTER_CLOCK),
    .rst_n (RESET_N),
    .rnd   (rnd)
  );

  assign STATE     = state;
  assign cells     = {5'd0, GAME_SIZE} * {5'd0, GAME_SIZE};
  assign cfg_ok    = legal_cfg(SIZE, COLOR_NUM);
  assign fill_hit  = {1'b0, rnd} < GAME_COLORS;
  assign pick_ok   = ({1'b0, PICK_COLOR} < GAME_COLORS) &&
                     (PICK_COLOR != CORNER_COLOR);
  assign tries_inc = TRIES + 8'd1;

  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      ACK_BEGIN_GAME <= 1'b0;
      FLOOD_START    <= 1'b0;
      WR_EN          <= 1'b0;
      WR_ADDR        <= '0;
      WR_DATA        <= '0;
      FLOOD_COLOR    <= '0;
      CORNER_COLOR   <= '0;
      TRIES          <= 8'd0;
      TOTAL_TRIES    <= 8'd0;
      GAME_SIZE      <= DEFAULT_SIZE;
      GAME_COLORS    <= DEFAULT_COLORS;
      cnt            <= '0;
    end else begin
      ACK_BEGIN_GAME <= 1'b0;
      FLOOD_START    <= 1'b0;
      WR_EN          <= 1'b0;
      if (ABORT) begin
        state <= S_IDLE;
        TRIES <= 8'd0;
      end else begin
        unique case (state)
          S_IDLE, S_WIN, S_LOSE: begin
            if (BEGIN_GAME) begin
              if (cfg_ok) begin
                GAME_SIZE   <= SIZE;
                GAME_COLORS <= COLOR_NUM;
                TOTAL_TRIES <= budget(SIZE, COLOR_NUM);
              end else begin
                GAME_SIZE   <= DEFAULT_SIZE;
                GAME_COLORS <= DEFAULT_COLORS;
                TOTAL_TRIES <= budget(DEFAULT_SIZE, DEFAULT_COLORS);
              end
              TRIES          <= 8'd0;
              cnt            <= '0;
              ACK_BEGIN_GAME <= 1'b1;
              state          <= S_ACK;
            end
          end
          // Fill starts on the ack cycle so the first write lands right after it.
          S_ACK, S_FILL: begin
            if (cnt == cells) begin
              state <= S_PLAY;
            end else begin
              state <= S_FILL;
              if (fill_hit) begin
                WR_EN   <= 1'b1;
                WR_ADDR <= cnt;
                WR_DATA <= rnd;
                cnt     <= cnt + CELL_AW'(1);
                if (cnt == '0) CORNER_COLOR <= rnd;
              end
            end
          end
          S_PLAY: begin
            if (PICK_VALID && pick_ok) begin
              FLOOD_START <= 1'b1;
              FLOOD_COLOR <= PICK_COLOR;
              state       <= S_FLOOD;
            end
          end
          S_FLOOD: begin
            if (FLOOD_DONE) begin
              TRIES        <= tries_inc;
              CORNER_COLOR <= FLOOD_COLOR;
              if (FLOOD_WON)                   state <= S_WIN;
              else if (tries_inc == TOTAL_TRIES) state <= S_LOSE;
              else                             state <= S_PLAY;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Directed and randomized bench for flood_game_ctrl with a behavioural
// model of the board fill, try budget and game outcome.
module tb_flood_game_ctrl;
  import flood_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       begin_game = 1'b0;
  logic       abort = 1'b0;
  logic       pick_valid = 1'b0;
  logic       flood_done = 1'b0;
  logic       flood_won = 1'b0;
  logic [4:0] size = '0;
  logic [3:0] color_num = '0;
  logic [2:0] pick_color = '0;

  logic       ack, fs, wr_en;
  logic [2:0] fc, wr_data, corner, st;
  logic [9:0] wr_addr;
  logic [4:0] game_size;
  logic [3:0] game_colors;
  logic [7:0] tries, total_tries;

  flood_game_ctrl #(.SEED(16'hACE1)) dut (
    .MASTER_CLOCK   (clk),
    .RESET_N        (rst_n),
    .BEGIN_GAME     (begin_game),
    .ACK_BEGIN_GAME (ack),
    .SIZE           (size),
    .COLOR_NUM      (color_num),
    .ABORT          (abort),
    .PICK_VALID     (pick_valid),
    .PICK_COLOR     (pick_color),
    .FLOOD_START    (fs),
    .FLOOD_COLOR    (fc),
    .FLOOD_DONE     (flood_done),
    .FLOOD_WON      (flood_won),
    .WR_EN          (wr_en),
    .WR_ADDR        (wr_addr),
    .WR_DATA        (wr_data),
    .GAME_SIZE      (game_size),
    .GAME_COLORS    (game_colors),
    .CORNER_COLOR   (corner),
    .TRIES          (tries),
    .TOTAL_TRIES    (total_tries),
    .STATE          (st)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int bt [7][6] = '{
    '{1, 2, 2, 3, 4, 4},
    '{5, 7, 8, 10, 12, 14},
    '{8, 11, 14, 17, 20, 23},
    '{12, 16, 20, 25, 29, 33},
    '{16, 21, 26, 32, 37, 42},
    '{19, 26, 32, 39, 45, 52},
    '{23, 30, 38, 46, 54, 61}
  };

  int m_size, m_colors, m_total, m_tries, m_corner;
  state_t m_state;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  logic [15:0] lf;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lf <= 16'hACE1;
    else        lf <= lfsr_step(lf);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset();
    chk("rst_state", st, S_IDLE);
    chk("rst_ack", ack, 0);
    chk("rst_fs", fs, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_fc", fc, 0);
    chk("rst_corner", corner, 0);
    chk("rst_tries", tries, 0);
    chk("rst_total", total_tries, 0);
    chk("rst_size", game_size, 14);
    chk("rst_colors", game_colors, 6);
  endtask

  task automatic fill(input int stop_after);
    int cells, writes, cyc;
    bit done, hit;
    cells = m_size * m_size;
    writes = 0;
    cyc = 0;
    done = 0;
    while (!done && cyc < 6000) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk("ack_one_cycle", ack, 0);
        begin_game = 1'b0;
      end
      if (writes < cells) begin
        hit = int'(lf[2:0]) < m_colors;
        chk("fill_state", st, S_FILL);
        chk("fill_wr_en", wr_en, hit);
        if (hit) begin
          chk("fill_addr", wr_addr, writes);
          chk("fill_data", wr_data, lf[2:0]);
          if (writes == 0) m_corner = int'(lf[2:0]);
          writes++;
        end
      end else begin
        chk("fill_play", st, S_PLAY);
        chk("fill_end_wr_en", wr_en, 0);
        chk("fill_corner", corner, m_corner);
        m_state = S_PLAY;
        done = 1;
      end
      if (stop_after != 0 && cyc >= stop_after) begin
        m_state = S_FILL;
        done = 1;
      end
    end
    if (!done) chk("fill_timeout", 0, 1);
  endtask

  task automatic start_game(input int s, input int c, input int stop_after);
    bit legal;
    begin_game = 1'b1;
    size = 5'(s);
    color_num = 4'(c);
    tick();
    legal = (s inside {2, 6, 10, 14, 18, 22, 26}) && c >= 3 && c <= 8;
    m_size = legal ? s : 14;
    m_colors = legal ? c : 6;
    m_total = bt[(m_size - 2) / 4][m_colors - 3];
    m_tries = 0;
    m_state = S_ACK;
    chk("ack", ack, 1);
    chk("ack_state", st, S_ACK);
    chk("game_size", game_size, m_size);
    chk("game_colors", game_colors, m_colors);
    chk("total_tries", total_tries, m_total);
    chk("tries_clr", tries, 0);
    fill(stop_after);
  endtask

  task automatic pick(input int col, input bit won, input int dly);
    bit legal;
    legal = col < m_colors && col != m_corner;
    pick_valid = 1'b1;
    pick_color = 3'(col);
    tick();
    pick_valid = 1'b0;
    chk("flood_start", fs, legal);
    if (!legal) begin
      chk("pick_ign_state", st, S_PLAY);
      chk("pick_ign_tries", tries, m_tries);
      return;
    end
    chk("flood_color", fc, col);
    chk("flood_state", st, S_FLOOD);
    for (int i = 0; i < dly; i++) begin
      pick_valid = 1'b1;
      pick_color = 3'($urandom);
      tick();
      pick_valid = 1'b0;
      chk("flood_wait_state", st, S_FLOOD);
      chk("flood_start_once", fs, 0);
      chk("flood_color_hold", fc, col);
    end
    flood_done = 1'b1;
    flood_won = won;
    tick();
    flood_done = 1'b0;
    flood_won = 1'b0;
    m_tries++;
    m_corner = col;
    m_state = won ? S_WIN : (m_tries == m_total ? S_LOSE : S_PLAY);
    chk("done_tries", tries, m_tries);
    chk("done_corner", corner, m_corner);
    chk("done_state", st, m_state);
  endtask

  task automatic do_abort(input bit with_done);
    abort = 1'b1;
    flood_done = with_done;
    tick();
    abort = 1'b0;
    flood_done = 1'b0;
    m_tries = 0;
    m_state = S_IDLE;
    chk("abort_state", st, S_IDLE);
    chk("abort_tries", tries, 0);
    chk("abort_wr_en", wr_en, 0);
  endtask

  initial begin
    int s, c;
    repeat (3) tick();
    check_reset();
    rst_n = 1'b1;
    repeat ($urandom_range(0, 20)) tick();

    // 2x2, 3 colours: single-try budget, win on the final try
    start_game(2, 3, 0);
    chk("budget_2_3", total_tries, 1);
    flood_done = 1'b1;
    flood_won = 1'b1;
    tick();
    flood_done = 1'b0;
    flood_won = 1'b0;
    chk("stray_done_state", st, S_PLAY);
    chk("stray_done_tries", tries, 0);
    pick((m_corner + 1) % 3, 1'b1, 1);
    chk("win_final", st, S_WIN);

    // 2x2, 4 colours: ignored picks, then lose after two tries
    start_game(2, 4, 0);
    pick(m_corner, 1'b0, 0);
    pick(7, 1'b0, 0);
    pick((m_corner + 1) % 4, 1'b0, 1);
    pick((m_corner + 1) % 4, 1'b0, 2);
    chk("lose_tries", tries, 2);
    chk("lose_state", st, S_LOSE);
    pick_valid = 1'b1;
    flood_done = 1'b1;
    repeat (3) tick();
    pick_valid = 1'b0;
    flood_done = 1'b0;
    chk("lose_hold_state", st, S_LOSE);
    chk("lose_hold_tries", tries, 2);
    chk("lose_hold_fs", fs, 0);

    // abort mid-fill together with a stray done, then another done pulse
    start_game(10, 5, 30);
    do_abort(1'b1);
    flood_done = 1'b1;
    tick();
    flood_done = 1'b0;
    chk("post_abort_state", st, S_IDLE);
    chk("post_abort_tries", tries, 0);

    // abort while a flood is in flight
    start_game(6, 3, 0);
    pick((m_corner + 1) % 3, 1'b0, 0);
    do_abort(1'b1);

    // asynchronous reset mid-fill
    start_game(26, 8, 50);
    #2 rst_n = 1'b0;
    #1 check_reset();
    tick();
    rst_n = 1'b1;
    m_state = S_IDLE;

    // illegal size falls back to 14/6
    start_game(7, 6, 0);
    chk("illegal_size", game_size, 14);
    chk("illegal_total", total_tries, 25);

    for (int g = 0; g < 6; g++) begin
      if (m_state != S_IDLE && m_state != S_WIN && m_state != S_LOSE)
        do_abort(1'b0);
      repeat ($urandom_range(0, 7)) tick();
      if ($urandom_range(0, 4) == 0) begin
        s = $urandom_range(0, 31);
        c = $urandom_range(0, 15);
      end else begin
        s = 2 + 4 * $urandom_range(0, 2);
        c = $urandom_range(3, 8);
      end
      start_game(s, c, 0);
      for (int k = 0; k < 80 && m_state == S_PLAY; k++)
        pick($urandom_range(0, 7), $urandom_range(0, 11) == 0,
             $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
